// File: rtl/mips_isa_pkg.sv
// ============================================================================
// Module      : mips_isa_pkg
// Description : Shared ISA constants, instruction fields and fetch FSM states
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_isa_pkg;

  localparam logic [5:0] c_op_addu = 6'd1;
  localparam logic [5:0] c_op_beq  = 6'd2;
  localparam logic [5:0] c_op_lw   = 6'd3;
  localparam logic [5:0] c_op_mult = 6'd4;
  localparam logic [5:0] c_op_addi = 6'd5;
  localparam logic [5:0] c_op_j    = 6'd6;
  localparam logic [5:0] c_op_nop  = 6'd7;

  // Bubble: nop opcode, every other field zero
  localparam logic [31:0] c_nop_word = 32'h1C00_0000;

  localparam int c_op_msb     = 31;
  localparam int c_op_lsb     = 26;
  localparam int c_rs_msb     = 25;
  localparam int c_rs_lsb     = 21;
  localparam int c_rt_msb     = 20;
  localparam int c_rt_lsb     = 16;
  localparam int c_rd_msb     = 15;
  localparam int c_rd_lsb     = 11;
  localparam int c_imm_msb    = 15;
  localparam int c_imm_lsb    = 0;
  localparam int c_target_msb = 25;
  localparam int c_target_lsb = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_t;

  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[c_op_msb:c_op_lsb];
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous prefetch FIFO with flush; head is read combinationally
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  import mips_isa_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra wrap bit distinguishes full from empty when the indices match
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign count = r_wr_ptr - r_rd_ptr;
  assign dout  = r_mem[r_rd_ptr[AW-1:0]];

  assign w_do_push = push && !full && !flush;
  assign w_do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : PC, single-outstanding imem handshake, prefetch FIFO, redirect
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
  import mips_isa_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter logic [31:0] PC_STEP    = 32'd1,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] NOP_WORD   = c_nop_word
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        pc_s,
  input  logic [31:0] npc,
  input  logic        stall,
  output logic [31:0] ir,
  output logic [31:0] pc_o,
  output logic        ir_valid
);

  localparam int AW = $clog2(FIFO_DEPTH);

  fetch_state_t r_state;
  fetch_state_t w_next_state;
  logic [31:0]  r_fetch_pc;
  logic [31:0]  r_addr;
  logic [31:0]  r_ir;
  logic [31:0]  r_pc_o;
  logic         r_ir_valid;

  logic         w_issue;
  logic         w_ack_ok;
  logic         w_bypass;
  logic         w_push;
  logic         w_pop;
  logic         w_full;
  logic         w_empty;
  logic [AW:0]  w_count;
  logic [63:0]  w_head;
  logic [31:0]  w_inflight;
  logic         w_issue_ok;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .flush (pc_s),
    .din   ({r_addr, imem_rdata}),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign imem_req   = (r_state != ST_IDLE);
  assign imem_addr  = r_addr;
  assign ir         = r_ir;
  assign pc_o       = r_pc_o;
  assign ir_valid   = r_ir_valid;

  assign w_inflight = 32'(w_count) + 32'(imem_req);
  assign w_issue_ok = !w_full && (w_inflight < 32'(FIFO_DEPTH));

  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    w_ack_ok     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!pc_s && w_issue_ok) begin
          w_issue      = 1'b1;
          w_next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_ack) begin
          w_ack_ok     = !pc_s;
          w_next_state = ST_IDLE;
        end else if (pc_s) begin
          w_next_state = ST_DROP;
        end
      end
      // An ack retires the abandoned request even if another redirect arrives
      ST_DROP: begin
        if (imem_ack) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // An empty FIFO forwards the returning word straight to ir
  assign w_bypass = w_ack_ok && !stall && w_empty;
  assign w_push   = w_ack_ok && !w_bypass;
  assign w_pop    = !pc_s && !stall && !w_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_fetch_pc <= RESET_PC;
      r_addr     <= RESET_PC;
    end else begin
      r_state <= w_next_state;
      if (pc_s)          r_fetch_pc <= npc;
      else if (w_ack_ok) r_fetch_pc <= r_fetch_pc + PC_STEP;
      if (w_issue)       r_addr <= r_fetch_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ir       <= NOP_WORD;
      r_pc_o     <= 32'd0;
      r_ir_valid <= 1'b0;
    end else if (pc_s) begin
      r_ir       <= NOP_WORD;
      r_ir_valid <= 1'b0;
    end else if (!stall) begin
      if (w_pop) begin
        r_pc_o     <= w_head[63:32];
        r_ir       <= w_head[31:0];
        r_ir_valid <= 1'b1;
      end else if (w_bypass) begin
        r_pc_o     <= r_addr;
        r_ir       <= imem_rdata;
        r_ir_valid <= 1'b1;
      end else begin
        r_ir       <= NOP_WORD;
        r_ir_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
